// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes, mask mapping, picker FSM states.
// No logic of its own; constants and a helper only.
// Not applicable: no handshake lives here.
package maze_pkg;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } picker_state_t;

    // Bit i of a candidate mask stands for direction i.
    function automatic logic [3:0] dir_to_mask(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/nth_set_bit_4.sv
// Finds popcount, the r-th set bit (LSB first) and the lowest set bit of a 4-bit mask.
// Purely combinational, zero latency.
// No handshake; outputs follow inputs.
module nth_set_bit_4 (
    input  logic [3:0] mask,
    input  logic [1:0] r,
    output logic [2:0] count,
    output logic [1:0] index,
    output logic       in_range,
    output logic [1:0] lowest
);

    // Walk the mask once, counting set bits and catching the r-th one and the lowest one.
    always_comb begin
        logic [2:0] seen;
        seen   = 3'd0;
        index  = 2'd0;
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (seen == {1'b0, r}) begin
                    index = 2'(i);
                end
                seen = seen + 3'd1;
            end
        end
        count    = seen;
        in_range = ({1'b0, r} < seen);
    end

endmodule

// File: rtl/random_direction_picker.sv
// Picks a uniformly random legal maze direction from LFSR bits by rejection sampling.
// Latency: 1 edge for an empty mask, 2 edges for a first-draw hit, +SAMPLE_SPACING per rejection.
// Backpressure: result held with valid until ack; requests while busy are dropped, not queued.
module random_direction_picker
    import maze_pkg::*;
#(
    parameter int MAX_TRIES      = 8,
    parameter int SAMPLE_SPACING = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] lfsr_value,
    input  logic       request,
    input  logic [3:0] candidate_mask,
    input  logic       ack,
    output logic       busy,
    output logic       valid,
    output logic [1:0] direction,
    output logic       none_available,
    output logic       fallback
);

    picker_state_t state_q, state_d;
    logic [3:0]    mask_q;
    logic [3:0]    retry_q;
    logic [7:0]    space_q;

    logic [2:0]    pop_count;
    logic [1:0]    pick_index;
    logic          pick_in_range;
    logic [1:0]    pick_lowest;
    logic          draw_now;
    logic [3:0]    retry_inc;
    logic          retries_spent;

    // Only the two low LFSR bits feed a draw; the rest and the popcount are not needed here.
    logic          unused_bits;
    assign unused_bits = ^{lfsr_value[7:2], pop_count};

    nth_set_bit_4 u_nth_set_bit_4 (
        .mask     (mask_q),
        .r        (lfsr_value[1:0]),
        .count    (pop_count),
        .index    (pick_index),
        .in_range (pick_in_range),
        .lowest   (pick_lowest)
    );

    assign draw_now      = (state_q == ST_DRAW) && (space_q == 8'd0);
    assign retry_inc     = retry_q + 4'd1;
    assign retries_spent = (retry_inc == 4'(MAX_TRIES));

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept, draw until hit or retries exhausted, wait for ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    state_d = (candidate_mask == 4'b0000) ? ST_DONE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (draw_now && (pick_in_range || retries_spent)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; result fields come from the datapath registers.
    always_comb begin
        busy  = (state_q != ST_IDLE);
        valid = (state_q == ST_DONE);
    end

    // Datapath: latch mask on acceptance, run retry/spacing counters, capture the result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mask_q         <= 4'd0;
            retry_q        <= 4'd0;
            space_q        <= 8'd0;
            direction      <= DIR_N;
            none_available <= 1'b0;
            fallback       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (request) begin
                        mask_q         <= candidate_mask;
                        retry_q        <= 4'd0;
                        space_q        <= 8'd0;
                        none_available <= (candidate_mask == 4'b0000);
                        fallback       <= 1'b0;
                        direction      <= DIR_N;
                    end
                end
                ST_DRAW: begin
                    if (draw_now) begin
                        if (pick_in_range) begin
                            direction <= pick_index;
                            fallback  <= 1'b0;
                        end else begin
                            retry_q <= retry_inc;
                            space_q <= 8'(SAMPLE_SPACING - 1);
                            // Out of retries: settle on the lowest legal neighbour.
                            if (retries_spent) begin
                                direction <= pick_lowest;
                                fallback  <= 1'b1;
                            end
                        end
                    end else begin
                        space_q <= space_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_random_direction_picker.sv
module tb_random_direction_picker;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] lfsr_value;
    logic       request;
    logic [3:0] candidate_mask;
    logic       ack;
    logic       busy;
    logic       valid;
    logic [1:0] direction;
    logic       none_available;
    logic       fallback;

    int tests_run = 0;
    int tests_failed = 0;

    random_direction_picker #(.MAX_TRIES(8), .SAMPLE_SPACING(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .lfsr_value     (lfsr_value),
        .request        (request),
        .candidate_mask (candidate_mask),
        .ack            (ack),
        .busy           (busy),
        .valid          (valid),
        .direction      (direction),
        .none_available (none_available),
        .fallback       (fallback)
    );

    always #5 clock = ~clock;

    // One posedge, then settle 1 time unit so checks and new drives sit away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {busy, valid, none_available, fallback, direction} for compact checks.
    function automatic logic [15:0] outs();
        return {10'd0, busy, valid, none_available, fallback, direction};
    endfunction

    int cnt [4];
    int fb_cnt;
    int waited;

    initial begin
        reset = 1'b0; lfsr_value = 8'h00; request = 1'b0; candidate_mask = 4'h0; ack = 1'b0;
        tick(); tick();
        check("reset_state", outs(), 16'h0000);
        reset = 1'b1;

        // mask 1010, r=1 -> second set bit = W(3), valid at edge 2.
        request = 1'b1; candidate_mask = 4'b1010;
        tick();                                            // edge 1: acceptance
        check("m1010_e1", outs(), {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        request = 1'b0; candidate_mask = 4'b0001; lfsr_value = 8'h01;
        tick();                                            // edge 2: draw
        check("m1010_e2", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3});
        lfsr_value = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("m1010_hold", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3});
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("m1010_ack", outs(), {10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});

        // Empty mask -> none_available one edge after acceptance.
        request = 1'b1; candidate_mask = 4'b0000;
        tick();
        request = 1'b0;
        check("m0000", outs(), {10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0});
        ack = 1'b1; tick(); ack = 1'b0;
        check("m0000_ack", outs(), {10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0});

        // mask 0100 with r stuck at 3: eight rejections, fallback at edge 16.
        request = 1'b1; candidate_mask = 4'b0100; lfsr_value = 8'h03;
        tick();                                            // edge 1
        request = 1'b0;
        for (int e = 2; e <= 15; e++) begin
            tick();
            check("m0100_wait", {15'd0, valid}, 16'd0);
        end
        tick();                                            // edge 16
        check("m0100_fb", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2});
        ack = 1'b1; tick(); ack = 1'b0;
        check("m0100_after_ack", outs(), {10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2});

        // mask 1111: r=3 -> W at edge 2.
        request = 1'b1; candidate_mask = 4'b1111; lfsr_value = 8'h03;
        tick();
        request = 1'b0;
        tick();
        check("m1111_r3", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3});
        ack = 1'b1; tick(); ack = 1'b0;

        // Fresh request with r=0 -> N; a second request pulse while busy is dropped.
        request = 1'b1; candidate_mask = 4'b1111; lfsr_value = 8'h00;
        tick();                                            // accepted
        request = 1'b1;                                    // ignored: busy
        tick();
        request = 1'b0;
        check("m1111_r0", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
        ack = 1'b1; tick(); ack = 1'b0;
        check("busy_req_ack", {14'd0, busy, valid}, 16'd0);
        tick(); tick();
        check("busy_req_dropped", {14'd0, busy, valid}, 16'd0);

        // ack outside DONE does nothing.
        ack = 1'b1; tick(); ack = 1'b0;
        check("stray_ack", {14'd0, busy, valid}, 16'd0);

        // Reset mid-DRAW.
        request = 1'b1; candidate_mask = 4'b0100; lfsr_value = 8'h03;
        tick(); request = 1'b0; tick(); tick();
        reset = 1'b0; tick(); reset = 1'b1;
        check("rst_mid_draw", outs(), 16'h0000);
        tick(); tick();
        check("rst_mid_draw_no_result", outs(), 16'h0000);

        // Reset in DONE with ack pending: mask 1000, r=0 -> W, then reset.
        request = 1'b1; candidate_mask = 4'b1000; lfsr_value = 8'h00;
        tick(); request = 1'b0; tick();
        check("pre_rst_done", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3});
        reset = 1'b0; tick(); reset = 1'b1;
        check("rst_in_done", outs(), 16'h0000);

        // First request after reset: mask 0010, r=0 -> E at edge 2.
        request = 1'b1; candidate_mask = 4'b0010; lfsr_value = 8'h00;
        tick(); request = 1'b0;
        check("post_rst_e1", outs(), {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        tick();
        check("post_rst_e2", outs(), {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1});
        ack = 1'b1; tick(); ack = 1'b0;

        // Statistical run with a fresh random byte every cycle, mask 0111.
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        fb_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            request = 1'b1; candidate_mask = 4'b0111; lfsr_value = 8'($urandom);
            tick();
            request = 1'b0;
            waited = 0;
            while (!valid && waited < 40) begin
                lfsr_value = 8'($urandom);
                tick();
                waited++;
            end
            if (!valid) begin
                check("stat_timeout", {15'd0, valid}, 16'd1);
                break;
            end
            cnt[direction]++;
            if (fallback) fb_cnt++;
            ack = 1'b1; tick(); ack = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("stat_dir%0d_count=%0d", d, cnt[d]),
                  {15'd0, (cnt[d] >= 1200 && cnt[d] <= 1466)}, 16'd1);
        end
        check("stat_dir3_count", 16'(cnt[3]), 16'd0);
        check($sformatf("stat_fallback_count=%0d", fb_cnt), {15'd0, (fb_cnt < 40)}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/random_direction_picker.md
Name: random_direction_picker

Overview:
- Consumes the free-running 8-bit LFSR value and turns it into a uniformly chosen maze direction. The choice is restricted to the set of currently legal (unvisited) neighbours.
- Sits directly downstream of the LFSR and upstream of the maze-carving FSM, which issues one request per carve step.
- Uses a request/valid/ack handshake. Rejection sampling keeps the choice unbiased, and a bounded retry count guarantees termination.

Parameters:
- MAX_TRIES, 8, number of rejected draws before the deterministic fallback; legal range 1..15.
- SAMPLE_SPACING, 2, clock cycles between successive draws; must be ≥2 so consecutive draws use non-overlapping LFSR bits.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low; clock clock.
- lfsr_value  input  8  current LFSR output; changes every clock.
- request  input  1  carve FSM asks for a direction; sampled only when busy=0.
- candidate_mask  input  4  legal directions; bit i corresponds to direction i. Encoding: 0=N, 1=E, 2=S, 3=W.
- ack  input  1  carve FSM consumed the result; meaningful only while valid=1.
- busy  output  1  high from the cycle after acceptance until the cycle after ack.
- valid  output  1  result available; held until ack.
- direction  output  2  chosen direction; 0 when none_available=1.
- none_available  output  1  latched mask was 4'b0000.
- fallback  output  1  result came from the retry-exhausted path.

Behaviour:
- States: IDLE, DRAW, DONE.
- Reset (reset=0 at a posedge): state=IDLE; busy, valid, none_available and fallback all 0; direction=0; retry and spacing counters cleared. Reset overrides any state, including mid-DRAW and DONE with ack pending. No result is emitted for the aborted request.
- IDLE:
  - Remains in IDLE while request=0.
  - On a posedge with request=1: latch candidate_mask and clear the retry counter.
  - If the latched mask is 0: go to DONE with none_available=1, direction=0.
  - Otherwise: go to DRAW with the spacing counter set to 0, so the draw happens on the next edge.
- DRAW, on a posedge when the spacing counter is 0:
  - Draw r = lfsr_value[1:0] and compute k = popcount(mask).
  - If r < k: direction = index of the r-th set bit of the mask, counting from the LSB, r=0 being the lowest. Go to DONE with fallback=0.
  - Else: increment the retry counter and reload the spacing counter to SAMPLE_SPACING-1.
  - If the incremented retry counter equals MAX_TRIES: direction = lowest set bit, fallback=1, go to DONE.
  - When the spacing counter is non-zero: decrement it; no draw.
- DONE:
  - valid=1; direction, none_available and fallback are stable.
  - On a posedge with ack=1: go to IDLE. valid and busy drop after that edge; direction and flags hold their last values.
- Latency:
  - Mask 0: valid rises 1 edge after acceptance.
  - First draw accepted: valid rises 2 edges after the acceptance edge.
  - Each rejection adds SAMPLE_SPACING edges.
  - Worst case: 1 + MAX_TRIES·SAMPLE_SPACING − (SAMPLE_SPACING−1) edges.
- Handshake rules:
  - request while busy=1 is ignored; it is not queued.
  - The mask is sampled only on the acceptance edge; later changes have no effect.
  - ack outside DONE is ignored.
  - ack and request in the same DONE cycle: the ack completes the current result. The request is not accepted until the first IDLE cycle.
- Uniformity: for k=1..4, accepted outcomes are equiprobable given uniform r. The fallback path is the only bias source.

Decomposition:
- Shared package (maze_pkg):
  - Direction constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3.
  - Mask-bit ↔ direction mapping.
  - State encoding for this block's FSM.
- Sub-module nth_set_bit_4, purely combinational:
  - Inputs: mask[3:0], r[1:0].
  - Outputs: count[2:0] (popcount), index[1:0] (r-th set bit), in_range (r<count), lowest[1:0].

Test Plan:
- mask=4'b1010 accepted, lfsr_value[1:0]=2'b01 at the draw edge → valid 2 edges after acceptance; direction=3, fallback=0, none_available=0. Hold ack=0 for 5 cycles → outputs stable; ack=1 → valid=0 and busy=0 the next cycle.
- mask=4'b0000 → valid 1 edge after acceptance; none_available=1, direction=0.
- mask=4'b0100, lfsr_value[1:0] forced to 2'b11, MAX_TRIES=8, SAMPLE_SPACING=2 → valid at edge 16 after acceptance; direction=2, fallback=1.
- mask=4'b1111: draws r=3 then r=0 with spacing 2 → direction=3 at edge 2; on a fresh request, direction=0. A second request pulse while busy → ignored; only one valid.
- reset=0 asserted mid-DRAW, and again in DONE with valid=1 → the next cycle shows all outputs 0 and state IDLE. The first request after reset behaves as in a clean start.
- Integrated with the real LFSR (seed 8'hA5): 4000 requests with mask=4'b0111 → per-direction counts within ±10% of 1333; direction 3 never chosen; fallback rate < 1%.
